// File: rtl/arcade_input_pkg.sv
// Shared types and helpers for the arcade input front end: tread encoding,
// tread mode selection and the direction-to-tread mapping.
package arcade_input_pkg;

    typedef struct packed {
        logic l_fw;
        logic l_bk;
        logic r_fw;
        logic r_bk;
    } tread_t;

    typedef enum logic [1:0] {
        TM_DIGITAL = 2'd0,
        TM_ANALOG  = 2'd1,
        TM_OFF     = 2'd2
    } tread_mode_e;

    // Coin counter is sized for the largest 20-bit pulse length.
    localparam int unsigned COIN_PULSE_MAX = 20'hFFFFF;
    localparam int unsigned COIN_W         = $clog2(COIN_PULSE_MAX + 1);

    // udlr = {U, D, L, R}; conflicting or unlisted combinations stop both treads.
    function automatic tread_t dir_to_tread(input logic [3:0] udlr);
        tread_t t;
        case (udlr)
            4'b1000: t = tread_t'(4'b1010);
            4'b0100: t = tread_t'(4'b0101);
            4'b0010: t = tread_t'(4'b0110);
            4'b0001: t = tread_t'(4'b1001);
            4'b1010: t = tread_t'(4'b0010);
            4'b1001: t = tread_t'(4'b1000);
            4'b0101: t = tread_t'(4'b0100);
            4'b0110: t = tread_t'(4'b0001);
            default: t = tread_t'(4'b0000);
        endcase
        return t;
    endfunction

endpackage

// File: rtl/arcade_input_ctrl_axis_hyst.sv
// One signed analog axis to registered {neg, pos} engaged flags with
// separate engage/release thresholds.
module axis_hyst #(
    parameter logic [7:0] ANA_ON  = 8'd48,
    parameter logic [7:0] ANA_OFF = 8'd32
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              clear,
    input  logic signed [7:0] axis,
    output logic              neg,
    output logic              pos
);

    logic [7:0] mag;

    // -128 has no positive 8-bit counterpart, so it saturates to 127.
    assign mag = (axis == 8'sh80) ? 8'd127 :
                 axis[7]          ? 8'($unsigned(-axis)) : $unsigned(axis);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            neg <= 1'b0;
            pos <= 1'b0;
        end else if (clear) begin
            neg <= 1'b0;
            pos <= 1'b0;
        end else begin
            if (axis[7] && mag >= ANA_ON)       neg <= 1'b1;
            else if (mag < ANA_OFF)             neg <= 1'b0;
            if (!axis[7] && mag >= ANA_ON)      pos <= 1'b1;
            else if (mag < ANA_OFF)             pos <= 1'b0;
        end
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Input/config front end: per-player stick-to-tread mapping, coin stretching,
// and DIP / mod capture from the ioctl download stream.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PLAYERS = 2,
    parameter int          DSW_BYTES   = 8,
    parameter logic [7:0]  DSW_INDEX   = 8'd254,
    parameter logic [7:0]  MOD_INDEX   = 8'd1,
    parameter logic [7:0]  DSW_DEFAULT = 8'h00,
    parameter logic [19:0] COIN_PULSE  = 20'd1000000,
    parameter logic [7:0]  ANA_ON      = 8'd48,
    parameter logic [7:0]  ANA_OFF     = 8'd32
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     ioctl_wr,
    input  logic [7:0]               ioctl_index,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    input  logic [1:0]               tread_mode,
    input  logic [16*NUM_PLAYERS-1:0] joy,
    input  logic [16*NUM_PLAYERS-1:0] joya,
    output logic [4*NUM_PLAYERS-1:0] tread_o,
    output logic [NUM_PLAYERS-1:0]   fire_o,
    output logic [NUM_PLAYERS-1:0]   start_o,
    output logic [NUM_PLAYERS-1:0]   coin_o,
    output logic [8*DSW_BYTES-1:0]   dsw_o,
    output logic                     dsw_valid,
    output logic [7:0]               mod_o
);

    tread_mode_e mode;
    logic        hyst_clear;

    assign mode = tread_mode_e'(tread_mode);
    // Flags only run while analog mode is held, so any mode change starts them from zero.
    assign hyst_clear = (mode != TM_ANALOG);

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [15:0]       pj;
        logic              x_neg, x_pos, y_neg, y_pos;
        logic [3:0]        udlr;
        tread_t            tread_q;
        logic              fire_q, start_q, coin_prev;
        logic [COIN_W-1:0] coin_cnt;
        logic              unused_bits;

        assign pj          = joy[16*p +: 16];
        assign unused_bits = ^{pj[6], pj[15:8]};

        axis_hyst #(.ANA_ON(ANA_ON), .ANA_OFF(ANA_OFF)) u_x (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .clear   (hyst_clear),
            .axis    (joya[16*p +: 8]),
            .neg     (x_neg),
            .pos     (x_pos)
        );

        axis_hyst #(.ANA_ON(ANA_ON), .ANA_OFF(ANA_OFF)) u_y (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .clear   (hyst_clear),
            .axis    (joya[16*p+8 +: 8]),
            .neg     (y_neg),
            .pos     (y_pos)
        );

        // NOTE: assigning a default first keeps this block combinational; no latch is inferred.
        always_comb begin
            udlr = 4'b0000;
            case (mode)
                TM_DIGITAL: udlr = pj[3:0];
                TM_ANALOG:  udlr = {y_neg, y_pos, x_neg, x_pos};
                default:    udlr = 4'b0000;
            endcase
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                tread_q   <= '0;
                fire_q    <= 1'b0;
                start_q   <= 1'b0;
                coin_prev <= 1'b0;
                coin_cnt  <= '0;
            end else begin
                tread_q   <= dir_to_tread(udlr);
                fire_q    <= pj[4];
                start_q   <= pj[5];
                coin_prev <= pj[7];
                // A running pulse swallows further edges; no retrigger, no queueing.
                if (coin_cnt != '0)
                    coin_cnt <= coin_cnt - COIN_W'(1);
                else if (pj[7] && !coin_prev)
                    coin_cnt <= COIN_W'(COIN_PULSE);
            end
        end

        assign tread_o[4*p +: 4] = tread_q;
        assign fire_o[p]         = fire_q;
        assign start_o[p]        = start_q;
        assign coin_o[p]         = (coin_cnt != '0);
    end

    logic [7:0] dsw_q [DSW_BYTES];
    logic       dsw_wr;
    logic       mod_wr;

    assign dsw_wr = ioctl_wr && (ioctl_index == DSW_INDEX);
    assign mod_wr = ioctl_wr && (ioctl_index == MOD_INDEX);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: the DIP bank is reset on purpose so a partial download never survives reset.
            for (int k = 0; k < DSW_BYTES; k++)
                dsw_q[k] <= DSW_DEFAULT;
            dsw_valid <= 1'b0;
            mod_o     <= 8'hFF;
        end else begin
            if (dsw_wr) begin
                for (int k = 0; k < DSW_BYTES; k++)
                    if (ioctl_addr == 25'(k))
                        dsw_q[k] <= ioctl_dout;
                if (ioctl_addr == 25'(DSW_BYTES - 1))
                    dsw_valid <= 1'b1;
            end
            if (mod_wr)
                mod_o <= ioctl_dout;
        end
    end

    for (genvar k = 0; k < DSW_BYTES; k++) begin : g_dsw
        assign dsw_o[8*k +: 8] = dsw_q[k];
    end

endmodule
